sdram_port_arbiter: RTL and testbench

Shares the single Avalon-MM master port of the SDRAM controller between two requesters.
- Write port: frame loader, write-only.
- Read port: display/pattern reader, read-only.
Grants the bus in bounded bursts, never drops or alters a command stalled by waitrequest, and limits outstanding reads. Sits between the loader/reader blocks and the SDRAM controller instance.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/sdram_pend_counter.sv | 30 +++
 rtl/sdram_port_arbiter.sv | 84 ++++++++
 tb/tb_sdram_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: grant encoding and default sizing for the SDRAM port arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_t;
  localparam int ADDR_W_DEF    = 25;
  localparam int DATA_W_DEF    = 16;
  localparam int MAX_BURST_DEF = 8;
  localparam int MAX_PEND_DEF  = 4;
  localparam int PEND_W        = 4;
endpackage

// File: rtl/sdram_pend_counter.sv
// sdram_pend_counter: outstanding-read counter with full flag and sticky underflow error.
module sdram_pend_counter
  import sdram_arb_pkg::*;
#(
  parameter int MAX = MAX_PEND_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_cnt,
  output logic              o_full,
  output logic              o_err
);
  logic [PEND_W-1:0] r_cnt;
  logic              r_err;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_inc && !i_dec) r_cnt <= r_cnt + 1'b1;
      else if (i_dec && !i_inc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (i_dec && r_cnt == '0) r_err <= 1'b1;
    end
  end
  assign o_cnt  = r_cnt;
  assign o_full = r_cnt == PEND_W'(MAX);
  assign o_err  = r_err;
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-MM SDRAM master between a write-only loader
// and a read-only reader with bounded bursts and a cap on outstanding reads.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int MAX_PEND  = MAX_PEND_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iWR_REQ,
  input  logic [ADDR_W-1:0] iWR_ADDR,
  input  logic [DATA_W-1:0] iWR_DATA,
  output logic              oWR_WAIT,
  input  logic              iRD_REQ,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic              oRD_WAIT,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic              oRD_DATAVALID,
  output logic [ADDR_W-1:0] oSD_ADDR,
  output logic              oSD_WRITE,
  output logic              oSD_READ,
  output logic [DATA_W-1:0] oSD_WRITEDATA,
  input  logic              iSD_WAITREQUEST,
  input  logic [DATA_W-1:0] iSD_READDATA,
  input  logic              iSD_READDATAVALID,
  output logic [PEND_W-1:0] oPEND,
  output logic              oERR
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  gnt_t             r_gnt, w_gnt_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic w_pend_full, w_rd_ok, w_acc, w_lock, w_full, w_cur, w_oth;
  // A read port at the outstanding limit counts as not requesting.
  assign w_rd_ok       = iRD_REQ & !w_pend_full;
  assign oSD_WRITE     = (r_gnt == GNT_WR) & iWR_REQ;
  assign oSD_READ      = (r_gnt == GNT_RD) & w_rd_ok;
  assign oSD_ADDR      = r_gnt == GNT_WR ? iWR_ADDR : r_gnt == GNT_RD ? iRD_ADDR : '0;
  assign oSD_WRITEDATA = r_gnt == GNT_WR ? iWR_DATA : '0;
  assign oWR_WAIT      = !oSD_WRITE | iSD_WAITREQUEST;
  assign oRD_WAIT      = !oSD_READ | iSD_WAITREQUEST;
  assign oRD_DATA      = iSD_READDATA;
  assign oRD_DATAVALID = iSD_READDATAVALID;
  assign w_acc  = (oSD_WRITE | oSD_READ) & !iSD_WAITREQUEST;
  assign w_lock = (oSD_WRITE | oSD_READ) & iSD_WAITREQUEST;
  assign w_cur  = r_gnt == GNT_WR ? iWR_REQ : w_rd_ok;
  assign w_oth  = r_gnt == GNT_WR ? w_rd_ok : iWR_REQ;
  assign w_full = r_cnt + CNT_W'(w_acc) == CNT_W'(MAX_BURST);
  always_comb begin
    w_gnt_nx = r_gnt;
    w_cnt_nx = r_cnt;
    if (!w_lock) begin
      if (r_gnt == GNT_NONE) begin
        w_gnt_nx = w_rd_ok ? GNT_RD : iWR_REQ ? GNT_WR : GNT_NONE;
        w_cnt_nx = '0;
      end else if (w_cur && !w_full) begin
        w_cnt_nx = r_cnt + CNT_W'(w_acc);
      end else begin
        w_cnt_nx = '0;
        w_gnt_nx = w_oth ? (r_gnt == GNT_WR ? GNT_RD : GNT_WR) : w_cur ? r_gnt : GNT_NONE;
      end
    end
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_gnt <= GNT_NONE;
      r_cnt <= '0;
    end else begin
      r_gnt <= w_gnt_nx;
      r_cnt <= w_cnt_nx;
    end
  end
  sdram_pend_counter #(.MAX(MAX_PEND)) u_pend (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .i_inc  (oSD_READ & !iSD_WAITREQUEST),
    .i_dec  (iSD_READDATAVALID),
    .o_cnt  (oPEND),
    .o_full (w_pend_full),
    .o_err  (oERR)
  );
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed and randomized checks of the SDRAM port arbiter
// against a cycle-level reference model of the grant, burst and pending-read rules.
module tb_sdram_port_arbiter;
  localparam int MB = 8;
  localparam int MP = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0, wreq = 1'b0, dv = 1'b0;
  logic [24:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0, rdata = '0;
  logic        wr_wait, rd_wait, rd_dv, sd_write, sd_read, err;
  logic [15:0] rd_data, sd_wdata;
  logic [24:0] sd_addr;
  logic [3:0]  pend;
  int checks = 0, errors = 0;
  int m_gnt, m_cnt, m_pend;
  bit m_err, wr_acc, rd_acc;
  logic [15:0] rq[$];
  logic [15:0] mem[logic [24:0]];

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .iCLK(clk), .iRST_N(rst_n),
    .iWR_REQ(wr_req), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data), .oWR_WAIT(wr_wait),
    .iRD_REQ(rd_req), .iRD_ADDR(rd_addr), .oRD_WAIT(rd_wait),
    .oRD_DATA(rd_data), .oRD_DATAVALID(rd_dv),
    .oSD_ADDR(sd_addr), .oSD_WRITE(sd_write), .oSD_READ(sd_read), .oSD_WRITEDATA(sd_wdata),
    .iSD_WAITREQUEST(wreq), .iSD_READDATA(rdata), .iSD_READDATAVALID(dv),
    .oPEND(pend), .oERR(err)
  );

  function automatic logic [15:0] mem_rd(logic [24:0] a);
    return mem.exists(a) ? mem[a] : a[15:0] ^ 16'h5a5a;
  endfunction

  task automatic model_reset();
    m_gnt = 0; m_cnt = 0; m_pend = 0; m_err = 0;
    rq.delete();
    wr_req = 0; rd_req = 0; wreq = 0; dv = 0;
  endtask

  task automatic hw_reset();
    model_reset();
    #1 rst_n = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
  endtask

  // One bus cycle: compare all outputs at the falling edge, then advance the model.
  task automatic tick();
    bit rd_ok, ew, er, lock, cur, oth, full, eww, erw;
    logic [24:0] ea;
    logic [15:0] ed;
    @(negedge clk);
    rd_ok = rd_req && m_pend < MP;
    ew = m_gnt == 1 && wr_req;
    er = m_gnt == 2 && rd_ok;
    ea = m_gnt == 1 ? wr_addr : m_gnt == 2 ? rd_addr : '0;
    ed = m_gnt == 1 ? wr_data : '0;
    eww = !ew || wreq;
    erw = !er || wreq;
    wr_acc = ew && !wreq;
    rd_acc = er && !wreq;
    lock = (ew || er) && wreq;
    checks++;
    if ({sd_write, sd_read, sd_addr, sd_wdata} !== {ew, er, ea, ed}) begin
      errors++;
      $display("FAIL cmd @%0t: got w=%b r=%b a=%h d=%h, want w=%b r=%b a=%h d=%h",
               $time, sd_write, sd_read, sd_addr, sd_wdata, ew, er, ea, ed);
    end
    checks++;
    if ({wr_wait, rd_wait} !== {eww, erw}) begin
      errors++;
      $display("FAIL wait @%0t: got wr=%b rd=%b, want wr=%b rd=%b", $time, wr_wait, rd_wait, eww, erw);
    end
    checks++;
    if ({pend, err} !== {4'(m_pend), m_err}) begin
      errors++;
      $display("FAIL pend @%0t: got pend=%0d err=%b, want pend=%0d err=%b", $time, pend, err, m_pend, m_err);
    end
    checks++;
    if (rd_dv !== dv || (dv && rd_data !== rdata)) begin
      errors++;
      $display("FAIL rdret @%0t: got v=%b d=%h, want v=%b d=%h", $time, rd_dv, rd_data, dv, rdata);
    end
    if (wr_acc) mem[wr_addr] = wr_data;
    if (rd_acc) rq.push_back(mem_rd(rd_addr));
    if (dv && m_pend == 0) m_err = 1;
    if (rd_acc && !dv) m_pend++;
    else if (dv && !rd_acc && m_pend > 0) m_pend--;
    if (!lock) begin
      if (m_gnt == 0) begin
        m_gnt = rd_ok ? 2 : wr_req ? 1 : 0;
        m_cnt = 0;
      end else begin
        cur  = m_gnt == 1 ? wr_req : rd_ok;
        oth  = m_gnt == 1 ? rd_ok : wr_req;
        full = m_cnt + int'(wr_acc || rd_acc) == MB;
        if (cur && !full) m_cnt += int'(wr_acc || rd_acc);
        else begin
          m_cnt = 0;
          if (oth) m_gnt = 3 - m_gnt;
          else if (!cur) m_gnt = 0;
        end
      end
    end
    @(posedge clk) #1;
  endtask

  task automatic drive(int wait_pct, int dv_pct);
    wreq = $urandom_range(99) < wait_pct;
    dv = 0;
    if (rq.size() > 0 && $urandom_range(99) < dv_pct) begin
      dv = 1;
      rdata = rq.pop_front();
    end else rdata = 16'($urandom);
  endtask

  task automatic agents(int p_wr, int p_rd);
    if (wr_acc || !wr_req) begin
      wr_req  = $urandom_range(99) < p_wr;
      wr_addr = 25'($urandom);
      wr_data = 16'($urandom);
    end
    if (rd_acc || !rd_req) begin
      rd_req  = $urandom_range(99) < p_rd;
      rd_addr = 25'($urandom);
    end
  endtask

  task automatic run(int n, int p_wr, int p_rd, int wait_pct, int dv_pct);
    repeat (n) begin
      drive(wait_pct, dv_pct);
      tick();
      agents(p_wr, p_rd);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if ({sd_write, sd_read, wr_wait, rd_wait, pend, err} !== {1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got w=%b r=%b ww=%b rw=%b pend=%0d err=%b, want 0 0 1 1 0 0",
               sd_write, sd_read, wr_wait, rd_wait, pend, err);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    tick();
  endtask

  task automatic test_first_read();
    rd_addr = 25'h1A0;
    rd_req = 1;
    tick();
    checks++;
    if (sd_read !== 1'b1 || sd_addr !== 25'h1A0) begin
      errors++;
      $display("FAIL first_read: got r=%b a=%h, want r=1 a=%h", sd_read, sd_addr, 25'h1A0);
    end
    tick();
    rd_req = 0;
    checks++;
    if (pend !== 4'd1) begin
      errors++;
      $display("FAIL first_pend: got %0d, want 1", pend);
    end
    dv = 1;
    rdata = rq.pop_front();
    tick();
    dv = 0;
  endtask

  task automatic test_alternate();
    int seq[$];
    int bad = -1;
    hw_reset();
    agents(100, 100);
    repeat (40) begin
      drive(0, 100);
      tick();
      if (rd_acc) seq.push_back(2);
      if (wr_acc) seq.push_back(1);
      agents(100, 100);
    end
    for (int i = 0; i < 32 && i < seq.size(); i++)
      if (bad < 0 && seq[i] != ((i / 8) % 2 == 0 ? 2 : 1)) bad = i;
    checks++;
    if (seq.size() < 32 || bad >= 0) begin
      errors++;
      $display("FAIL alternate: got %0d accepts, first wrong index %0d, want 32+ accepts as 8 RD/8 WR runs",
               seq.size(), bad);
    end
  endtask

  task automatic test_stall();
    logic [24:0] a;
    logic [15:0] d;
    bit seen = 0;
    hw_reset();
    wr_req = 1; wr_addr = 25'h0ABCDE; wr_data = 16'hC3A5;
    a = wr_addr; d = wr_data;
    tick();
    wreq = 1; rd_req = 1; rd_addr = 25'h000777;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({sd_write, sd_read, sd_addr, sd_wdata} !== {1'b1, 1'b0, a, d}) begin
        errors++;
        $display("FAIL stall%0d: got w=%b r=%b a=%h d=%h, want w=1 r=0 a=%h d=%h",
                 i, sd_write, sd_read, sd_addr, sd_wdata, a, d);
      end
      tick();
    end
    wreq = 0;
    #1;
    checks++;
    if (wr_wait !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got wr_wait=%b, want 0", wr_wait);
    end
    tick();
    agents(0, 100);
    for (int i = 0; i < 4 && !seen; i++) begin
      dv = 0;
      tick();
      seen = rd_acc;
      agents(0, 100);
    end
    checks++;
    if (!seen || sd_write !== 1'b0) begin
      errors++;
      $display("FAIL stall_switch: got read_seen=%b w=%b, want read_seen=1 w=0", seen, sd_write);
    end
  endtask

  task automatic test_pend_limit();
    bit seen = 0;
    hw_reset();
    rd_req = 1; rd_addr = 25'h100;
    repeat (8) begin
      tick();
      agents(0, 100);
    end
    checks++;
    if (pend !== 4'd4 || rd_wait !== 1'b1) begin
      errors++;
      $display("FAIL pend_full: got pend=%0d rd_wait=%b, want pend=4 rd_wait=1", pend, rd_wait);
    end
    wr_req = 1; wr_addr = 25'h100; wr_data = 16'h1234;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = wr_acc;
      agents(0, 100);
    end
    checks++;
    if (!seen || pend !== 4'd4) begin
      errors++;
      $display("FAIL pend_wr: got write_seen=%b pend=%0d, want write_seen=1 pend=4", seen, pend);
    end
    dv = 1;
    rdata = rq.pop_front();
    tick();
    dv = 0;
    checks++;
    if (pend !== 4'd3) begin
      errors++;
      $display("FAIL pend_ret: got %0d, want 3", pend);
    end
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      seen = rd_acc;
      agents(0, 100);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL pend_resume: got no read accept, want read accept");
    end
  endtask

  task automatic test_same_cycle();
    hw_reset();
    rd_req = 1; rd_addr = 25'h2000;
    for (int i = 0; i < 6 && pend !== 4'd2; i++) begin
      tick();
      agents(0, 100);
    end
    dv = 1;
    rdata = rq.pop_front();
    #1;
    checks++;
    if (sd_read !== 1'b1 || rd_wait !== 1'b0 || pend !== 4'd2) begin
      errors++;
      $display("FAIL same_pre: got r=%b rw=%b pend=%0d, want r=1 rw=0 pend=2", sd_read, rd_wait, pend);
    end
    tick();
    agents(0, 0);
    checks++;
    if (pend !== 4'd2) begin
      errors++;
      $display("FAIL same_cycle: got pend=%0d, want 2", pend);
    end
    for (int i = 0; i < 8 && rq.size() > 0; i++) begin
      dv = 1;
      rdata = rq.pop_front();
      tick();
    end
    dv = 1;
    rdata = 16'hBEEF;
    tick();
    dv = 0;
    checks++;
    if (pend !== 4'd0 || err !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got pend=%0d err=%b, want pend=0 err=1", pend, err);
    end
    tick();
  endtask

  task automatic test_async_reset();
    rd_req = 1; rd_addr = 25'h3000;
    for (int i = 0; i < 8 && pend !== 4'd3; i++) begin
      tick();
      agents(0, 100);
    end
    wreq = 1;
    tick();
    checks++;
    if (sd_read !== 1'b1 || pend !== 4'd3) begin
      errors++;
      $display("FAIL areset_pre: got r=%b pend=%0d, want r=1 pend=3", sd_read, pend);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({sd_write, sd_read, wr_wait, rd_wait, pend, err} !== {1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL areset: got w=%b r=%b ww=%b rw=%b pend=%0d err=%b, want 0 0 1 1 0 0",
               sd_write, sd_read, wr_wait, rd_wait, pend, err);
    end
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    tick();
  endtask

  task automatic test_random();
    hw_reset();
    run(800, 60, 60, 30, 40);
    run(20, 0, 0, 0, 100);
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_alternate();
    test_stall();
    test_pend_limit();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
